// File: rtl/mcpu_mem_ctrl.sv
// mcpu_mem_ctrl: memory owner and run scheduler for the 6-bit minimal CPU
//
// Owns the 16x6 program/data memory. It shares the memory between the host command
// port and the CPU core. It holds the core in reset until the host grants a run slot.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   host_valid      command valid; accepted when host_valid & host_ready
//   host_ready      combinational: all commands accepted when halted, only HALT when running
//   host_cmd        00 WRITE, 01 READ, 10 RUN, 11 HALT
//   host_addr       WRITE/READ address
//   host_data       WRITE data, or RUN cycle limit (0 = free-run)
//   rsp_valid/data  one-cycle READ response, registered
//   cpu_rst_n       active-low core reset, high exactly while running
//   cpu_addr/wdata  demultiplexed core address and accumulator
//   cpu_we_n        core write enable, active low, honoured only while running
//   cpu_rdata       combinational mem[cpu_addr]
//   running         high while running
//   done            one-cycle pulse when a cycle-limited run expires
//
// Configuration: MCPU_CTRL_CYCLE_LIMIT_EN enables the RUN cycle limit and done.
// Without the macro, every RUN is a free-run and done is tied low.
module mcpu_mem_ctrl #(
    parameter int MEM_DEPTH = 16,
    parameter int DW        = 6,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic [1:0]    host_cmd,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          cpu_rst_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we_n,
    output logic [DW-1:0] cpu_rdata,
    output logic          running,
    output logic          done
);
    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;
    localparam logic [1:0] CMD_HALT  = 2'b11;

    typedef enum logic {ST_HALTED, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem_q [MEM_DEPTH];
    logic [DW-1:0] mem_d [MEM_DEPTH];
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          run_q, run_d;
    logic          acc;
`ifdef MCPU_CTRL_CYCLE_LIMIT_EN
    logic [DW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
`endif

    always_comb begin
        host_ready  = rst & ((state_q == ST_HALTED) | (host_cmd == CMD_HALT));
        acc         = host_valid & host_ready;
        state_d     = state_q;
        mem_d       = mem_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef MCPU_CTRL_CYCLE_LIMIT_EN
        cnt_d       = cnt_q;
        done_d      = 1'b0;
`endif
        if (state_q == ST_HALTED) begin
            if (acc && host_cmd == CMD_WRITE) mem_d[host_addr] = host_data;
            if (acc && host_cmd == CMD_READ) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_q[host_addr];
            end
            if (acc && host_cmd == CMD_RUN) begin
                state_d = ST_RUN;
`ifdef MCPU_CTRL_CYCLE_LIMIT_EN
                cnt_d   = host_data;
`endif
            end
        end else begin
            if (!cpu_we_n) mem_d[cpu_addr] = cpu_wdata;
`ifdef MCPU_CTRL_CYCLE_LIMIT_EN
            // expiry takes priority over a HALT accepted on the same edge so done still pulses
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (cnt_q == DW'(1)) begin
                state_d = ST_HALTED;
                done_d  = 1'b1;
            end else if (acc) begin
                state_d = ST_HALTED;
            end
`else
            if (acc) state_d = ST_HALTED;
`endif
        end
        run_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_HALTED;
            mem_q       <= '{default: '0};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            run_q       <= run_d;
        end
    end

`ifdef MCPU_CTRL_CYCLE_LIMIT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign cpu_rst_n = run_q;
    assign running   = run_q;
    assign cpu_rdata = mem_q[cpu_addr];
endmodule

// File: tb/tb_mcpu_mem_ctrl.sv
// tb_mcpu_mem_ctrl: table, directed and randomized checks of mcpu_mem_ctrl against a behavioural model
module tb_mcpu_mem_ctrl;
    localparam logic [1:0] WR = 2'b00;
    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] RN = 2'b10;
    localparam logic [1:0] HT = 2'b11;
`ifdef MCPU_CTRL_CYCLE_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [1:0] host_cmd = 2'b00;
    logic [3:0] host_addr = 4'd0;
    logic [5:0] host_data = 6'd0;
    logic       rsp_valid;
    logic [5:0] rsp_data;
    logic       cpu_rst_n;
    logic [3:0] cpu_addr = 4'd0;
    logic [5:0] cpu_wdata = 6'd0;
    logic       cpu_we_n = 1'b1;
    logic [5:0] cpu_rdata;
    logic       running;
    logic       done;

    mcpu_mem_ctrl dut (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
        .host_cmd(host_cmd), .host_addr(host_addr), .host_data(host_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cpu_rst_n(cpu_rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we_n(cpu_we_n),
        .cpu_rdata(cpu_rdata), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: memory contents, run flag and remaining cycles of a limited run
    logic [5:0] m_mem [16];
    bit         m_run;
    int         m_left;
    bit         m_done;
    bit         m_rv;
    logic [5:0] m_rd;
    logic       last_ready;

    typedef struct {
        logic [1:0] cmd;
        logic [3:0] a;
        logic [5:0] d;
        logic       e_ready;
        logic       e_rv;
        logic [5:0] e_rd;
        logic       e_crn;
    } vec_t;
    vec_t tbl [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 6'd0;
        m_run  = 1'b0;
        m_left = 0;
        m_done = 1'b0;
        m_rv   = 1'b0;
        m_rd   = 6'd0;
    endtask

    task automatic host(input bit v, input logic [1:0] c, input logic [3:0] a, input logic [5:0] d);
        host_valid = v;
        host_cmd   = c;
        host_addr  = a;
        host_data  = d;
    endtask

    task automatic cpu(input bit we_n, input logic [3:0] a, input logic [5:0] d);
        cpu_we_n  = we_n;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic cycle();
        bit r, v, we, rdy;
        logic [1:0] c;
        logic [3:0] a, ca;
        logic [5:0] d, wd;
        @(negedge clk);
        r = rst; v = host_valid; c = host_cmd; a = host_addr; d = host_data;
        we = cpu_we_n; ca = cpu_addr; wd = cpu_wdata;
        rdy = r && (!m_run || c == HT);
        last_ready = host_ready;
        chk("host_ready", host_ready, rdy);
        chk("cpu_rdata", cpu_rdata, m_mem[ca]);
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            m_rv   = 1'b0;
            if (!m_run) begin
                if (v) begin
                    case (c)
                        WR: m_mem[a] = d;
                        RD: begin m_rv = 1'b1; m_rd = m_mem[a]; end
                        RN: begin m_run = 1'b1; m_left = LIMIT ? int'(d) : 0; end
                        default: ;
                    endcase
                end
            end else begin
                if (!we) m_mem[ca] = wd;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin m_run = 1'b0; m_done = 1'b1; end
                end
                if (m_run && v && c == HT) m_run = 1'b0;
            end
        end
        #1;
        chk("cpu_rst_n", cpu_rst_n, m_run);
        chk("running", running, m_run);
        chk("done", done, m_done);
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_rv || !r) chk("rsp_data", rsp_data, m_rd);
    endtask

    initial begin
        logic [1:0] c;
        for (int i = 0; i < 16; i++) begin
            tbl[2*i]   = '{WR, 4'(i), 6'(i ^ 'h2A), 1'b1, 1'b0, 6'd0, 1'b0};
            tbl[2*i+1] = '{RD, 4'(i), 6'd0, 1'b1, 1'b1, 6'(i ^ 'h2A), 1'b0};
        end
        model_reset();
        cpu(1'b1, 4'd0, 6'd0);
        host(1'b1, RN, 4'd0, 6'd3);
        repeat (2) cycle();
        chk("reset_ready", last_ready, 1'b0);
        rst = 1'b1;
        host(1'b0, WR, 4'd0, 6'd0);
        cycle();

        // load and readback
        for (int k = 0; k < 32; k++) begin
            host(1'b1, tbl[k].cmd, tbl[k].a, tbl[k].d);
            cpu(1'b1, tbl[k].a, 6'd0);
            cycle();
            chk("tbl_ready", last_ready, tbl[k].e_ready);
            chk("tbl_rsp_valid", rsp_valid, tbl[k].e_rv);
            if (tbl[k].e_rv) chk("tbl_rsp_data", rsp_data, tbl[k].e_rd);
            chk("tbl_cpu_rst_n", cpu_rst_n, tbl[k].e_crn);
        end
        host(1'b0, WR, 4'd0, 6'd0);

        // limited run of 5 (free-run when the limit is compiled out)
        host(1'b1, RN, 4'd0, 6'd5);
        cycle();
        chk("run_start", cpu_rst_n, 1'b1);
        host(1'b0, WR, 4'd0, 6'd0);
`ifdef MCPU_CTRL_CYCLE_LIMIT_EN
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("lim_cpu_rst_n", cpu_rst_n, k < 5);
            chk("lim_done", done, k == 5);
        end
`else
        for (int k = 1; k <= 10; k++) begin
            cycle();
            chk("free_cpu_rst_n", cpu_rst_n, 1'b1);
            chk("free_done", done, 1'b0);
        end
        host(1'b1, HT, 4'd0, 6'd0);
        cycle();
        chk("free_halt", cpu_rst_n, 1'b0);
`endif

        // free-run, CPU write on the same edge as HALT
        host(1'b1, RN, 4'd0, 6'd0);
        cycle();
        host(1'b0, WR, 4'd0, 6'd0);
        repeat (2) cycle();
        cpu(1'b0, 4'd9, 6'h15);
        host(1'b1, HT, 4'd0, 6'd0);
        cycle();
        chk("halt_cpu_rst_n", cpu_rst_n, 1'b0);
        chk("halt_done", done, 1'b0);
        cpu(1'b1, 4'd0, 6'd0);
        host(1'b1, RD, 4'd9, 6'd0);
        cycle();
        chk("cpuwr_read", rsp_data, 6'h15);

        // host WRITE stalls while running
        host(1'b1, RN, 4'd0, 6'd0);
        cycle();
        host(1'b1, WR, 4'd2, 6'd7);
        cpu(1'b1, 4'd2, 6'd0);
        repeat (3) begin
            cycle();
            chk("stall_ready", last_ready, 1'b0);
            chk("stall_mem", cpu_rdata, 6'h28);
        end
        host(1'b1, HT, 4'd0, 6'd0);
        cycle();
        host(1'b1, WR, 4'd2, 6'd7);
        cycle();
        chk("stall_accept", last_ready, 1'b1);
        host(1'b1, RD, 4'd2, 6'd0);
        cycle();
        chk("stall_read", rsp_data, 6'd7);

        // reset in the middle of a limited run
        host(1'b1, RN, 4'd0, 6'd20);
        cycle();
        host(1'b0, WR, 4'd0, 6'd0);
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cpu(1'b1, 4'(i), 6'd0);
            cycle();
            chk("rst_mem", cpu_rdata, 6'd0);
            chk("rst_no_done", done, 1'b0);
        end

        // randomized traffic against the model
        repeat (600) begin
            rst = ($urandom_range(0, 59) != 0);
            c = 2'($urandom);
            host(1'($urandom), c, 4'($urandom), c == RN ? 6'($urandom_range(0, 12)) : 6'($urandom));
            cpu($urandom_range(0, 2) != 0, 4'($urandom), 6'($urandom));
            cycle();
        end
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
